// File: rtl/fix_msg_transmitter.sv
// fix_msg_transmitter
// Serialises FIX 4.2 admin messages (logon, logout, heartbeat, resendReq)
// requested by the session manager into a valid/ready byte stream. Header,
// body and trailer are generated on the fly; BodyLength is a per-type
// constant and CheckSum is a running mod-256 sum of the accepted bytes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   initiate_msg_i      request strobe, accepted when !busy_o
//   create_message_i    message type code
//   targetCompId_i      TargetCompID, 8 ASCII chars, first char in MSB
//   seq_num_i           MsgSeqNum, 8 BCD digits, first digit in MSB
//   begin_seq_i         BeginSeqNo for resendReq, 8 BCD digits
//   busy_o              message in progress
//   error_o             one-cycle pulse: unsupported type dropped
//   tx_data_o/valid_o/ready_i/last_o  byte stream toward TOE
//   done_o              one-cycle pulse after final byte accepted
module fix_msg_transmitter #(
  parameter int unsigned           VALUE_WIDTH    = 64,
  parameter logic [VALUE_WIDTH-1:0] SENDER_COMP_ID = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   initiate_msg_i,
  input  logic [3:0]             create_message_i,
  input  logic [VALUE_WIDTH-1:0] targetCompId_i,
  input  logic [31:0]            seq_num_i,
  input  logic [31:0]            begin_seq_i,
  output logic                   busy_o,
  output logic                   error_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   tx_last_o,
  output logic                   done_o
);

  localparam logic [3:0] MSG_LOGON      = 4'h1;
  localparam logic [3:0] MSG_LOGOUT     = 4'h2;
  localparam logic [3:0] MSG_HEARTBEAT  = 4'h3;
  localparam logic [3:0] MSG_RESEND_REQ = 4'h4;
  localparam logic [7:0] SOH            = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_BODY_COMMON, S_BODY_EXTRA, S_TRAILER
  } state_t;

  state_t                 state_q, state_d;
  logic [5:0]             idx_q, idx_d;
  logic [3:0]             type_q, type_d;
  logic [VALUE_WIDTH-1:0] target_q, target_d;
  logic [31:0]            seq_q, seq_d;
  logic [31:0]            begin_q, begin_d;
  logic [7:0]             csum_q, csum_d;
  logic                   error_q, error_d;
  logic                   done_q, done_d;

  logic [7:0] tx_byte;
  logic [5:0] last_idx;
  logic       fire;
  logic       supported;
  logic       has_extra;
  logic [7:0] type_char;
  logic [7:0] blen_tens, blen_units;
  logic [1:0] cs_hund;
  logic [3:0] cs_tens;
  logic [7:0] cs_rem;
  logic [2:0] tgt_k, beg_k;

  // Character k (0 = first) of an 8-char CompID.
  function automatic logic [7:0] comp_char(input logic [VALUE_WIDTH-1:0] v,
                                           input logic [2:0] k);
    return v[{~k, 3'b111} -: 8];
  endfunction

  // Digit k (0 = most significant) of an 8-digit BCD number, as ASCII.
  function automatic logic [7:0] bcd_char(input logic [31:0] v, input logic [2:0] k);
    return {4'h3, v[{~k, 2'b11} -: 4]};
  endfunction

  assign supported = (create_message_i == MSG_LOGON) || (create_message_i == MSG_LOGOUT) ||
                     (create_message_i == MSG_HEARTBEAT) || (create_message_i == MSG_RESEND_REQ);
  assign has_extra = (type_q == MSG_LOGON) || (type_q == MSG_RESEND_REQ);
  assign fire      = (state_q != S_IDLE) && tx_ready_i;
  // Field offsets: target starts at body index 20, BeginSeqNo at extra index 2.
  assign tgt_k     = idx_q[2:0] - 3'd4;
  assign beg_k     = idx_q[2:0] - 3'd2;

  always_comb begin
    type_char  = "0";
    blen_tens  = "4";
    blen_units = "1";
    case (type_q)
      MSG_LOGON:      begin type_char = "A"; blen_tens = "5"; blen_units = "4"; end
      MSG_LOGOUT:     begin type_char = "5"; end
      MSG_RESEND_REQ: begin type_char = "2"; blen_tens = "5"; blen_units = "7"; end
      default:        ;
    endcase
  end

  // Binary checksum to three decimal digits by compare-subtract.
  always_comb begin
    cs_rem  = csum_q;
    cs_hund = '0;
    cs_tens = '0;
    if (cs_rem >= 8'd200) begin
      cs_rem  = cs_rem - 8'd200;
      cs_hund = 2'd2;
    end else if (cs_rem >= 8'd100) begin
      cs_rem  = cs_rem - 8'd100;
      cs_hund = 2'd1;
    end
    for (int unsigned i = 0; i < 9; i++) begin
      if (cs_rem >= 8'd10) begin
        cs_rem  = cs_rem - 8'd10;
        cs_tens = cs_tens + 4'd1;
      end
    end
  end

  always_comb begin
    tx_byte  = '0;
    last_idx = '0;
    case (state_q)
      S_HDR: begin
        last_idx = 6'd14;
        case (idx_q)
          6'd0:    tx_byte = "8";
          6'd1:    tx_byte = "=";
          6'd2:    tx_byte = "F";
          6'd3:    tx_byte = "I";
          6'd4:    tx_byte = "X";
          6'd5:    tx_byte = ".";
          6'd6:    tx_byte = "4";
          6'd7:    tx_byte = ".";
          6'd8:    tx_byte = "2";
          6'd10:   tx_byte = "9";
          6'd11:   tx_byte = "=";
          6'd12:   tx_byte = blen_tens;
          6'd13:   tx_byte = blen_units;
          default: tx_byte = SOH;
        endcase
      end
      S_BODY_COMMON: begin
        last_idx = 6'd40;
        if (idx_q >= 6'd8 && idx_q <= 6'd15) begin
          tx_byte = comp_char(SENDER_COMP_ID, idx_q[2:0]);
        end else if (idx_q >= 6'd20 && idx_q <= 6'd27) begin
          tx_byte = comp_char(target_q, tgt_k);
        end else if (idx_q >= 6'd32 && idx_q <= 6'd39) begin
          tx_byte = bcd_char(seq_q, idx_q[2:0]);
        end else begin
          case (idx_q)
            6'd0:    tx_byte = "3";
            6'd1:    tx_byte = "5";
            6'd2:    tx_byte = "=";
            6'd3:    tx_byte = type_char;
            6'd5:    tx_byte = "4";
            6'd6:    tx_byte = "9";
            6'd7:    tx_byte = "=";
            6'd17:   tx_byte = "5";
            6'd18:   tx_byte = "6";
            6'd19:   tx_byte = "=";
            6'd29:   tx_byte = "3";
            6'd30:   tx_byte = "4";
            6'd31:   tx_byte = "=";
            default: tx_byte = SOH;
          endcase
        end
      end
      S_BODY_EXTRA: begin
        if (type_q == MSG_RESEND_REQ) begin
          last_idx = 6'd15;
          if (idx_q >= 6'd2 && idx_q <= 6'd9) begin
            tx_byte = bcd_char(begin_q, beg_k);
          end else begin
            case (idx_q)
              6'd0:    tx_byte = "7";
              6'd1:    tx_byte = "=";
              6'd11:   tx_byte = "1";
              6'd12:   tx_byte = "6";
              6'd13:   tx_byte = "=";
              6'd14:   tx_byte = "0";
              default: tx_byte = SOH;
            endcase
          end
        end else begin
          last_idx = 6'd12;
          case (idx_q)
            6'd0:    tx_byte = "9";
            6'd1:    tx_byte = "8";
            6'd2:    tx_byte = "=";
            6'd3:    tx_byte = "0";
            6'd5:    tx_byte = "1";
            6'd6:    tx_byte = "0";
            6'd7:    tx_byte = "8";
            6'd8:    tx_byte = "=";
            6'd9:    tx_byte = "0";
            6'd10:   tx_byte = "3";
            6'd11:   tx_byte = "0";
            default: tx_byte = SOH;
          endcase
        end
      end
      S_TRAILER: begin
        last_idx = 6'd6;
        case (idx_q)
          6'd0:    tx_byte = "1";
          6'd1:    tx_byte = "0";
          6'd2:    tx_byte = "=";
          6'd3:    tx_byte = {6'b001100, cs_hund};
          6'd4:    tx_byte = {4'h3, cs_tens};
          6'd5:    tx_byte = 8'h30 + cs_rem;
          default: tx_byte = SOH;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    type_d   = type_q;
    target_d = target_q;
    seq_d    = seq_q;
    begin_d  = begin_q;
    csum_d   = csum_q;
    error_d  = 1'b0;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (initiate_msg_i) begin
        if (supported) begin
          type_d   = create_message_i;
          target_d = targetCompId_i;
          seq_d    = seq_num_i;
          begin_d  = begin_seq_i;
          csum_d   = '0;
          idx_d    = '0;
          state_d  = S_HDR;
        end else begin
          error_d = 1'b1;
        end
      end
    end else if (fire) begin
      // The trailer ("10=", digits, SOH) never contributes to the sum.
      if (state_q != S_TRAILER) csum_d = csum_q + tx_byte;
      if (idx_q == last_idx) begin
        idx_d = '0;
        case (state_q)
          S_HDR:         state_d = S_BODY_COMMON;
          S_BODY_COMMON: state_d = has_extra ? S_BODY_EXTRA : S_TRAILER;
          S_BODY_EXTRA:  state_d = S_TRAILER;
          default: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        endcase
      end else begin
        idx_d = idx_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      type_q   <= '0;
      target_q <= '0;
      seq_q    <= '0;
      begin_q  <= '0;
      csum_q   <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      type_q   <= type_d;
      target_q <= target_d;
      seq_q    <= seq_d;
      begin_q  <= begin_d;
      csum_q   <= csum_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign tx_valid_o = (state_q != S_IDLE);
  assign tx_data_o  = tx_byte;
  assign tx_last_o  = (state_q == S_TRAILER) && (idx_q == 6'd6);
  assign error_o    = error_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_fix_msg_transmitter.sv
module tb_fix_msg_transmitter;

  localparam logic [3:0]  T_LOGON   = 4'h1;
  localparam logic [3:0]  T_LOGOUT  = 4'h2;
  localparam logic [3:0]  T_HB      = 4'h3;
  localparam logic [3:0]  T_RESEND  = 4'h4;
  localparam logic [63:0] SENDER    = "SENDRA01";

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic        initiate_msg_i;
  logic [3:0]  create_message_i;
  logic [63:0] targetCompId_i;
  logic [31:0] seq_num_i, begin_seq_i;
  logic        tx_ready_i;
  logic        busy_o, error_o, tx_valid_o, tx_last_o, done_o;
  logic [7:0]  tx_data_o;

  int checks = 0;
  int errors = 0;
  bq_t mq;
  bq_t hb_ref;

  always #5 clk = ~clk;

  fix_msg_transmitter #(.VALUE_WIDTH(64), .SENDER_COMP_ID(SENDER)) dut (
    .clk(clk), .rst(rst), .initiate_msg_i(initiate_msg_i),
    .create_message_i(create_message_i), .targetCompId_i(targetCompId_i),
    .seq_num_i(seq_num_i), .begin_seq_i(begin_seq_i), .busy_o(busy_o),
    .error_o(error_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .tx_last_o(tx_last_o), .done_o(done_o)
  );

  function automatic void app_str(input string s);
    for (int i = 0; i < s.len(); i++) mq.push_back(s[i]);
  endfunction

  function automatic void app_comp(input logic [63:0] v);
    for (int i = 0; i < 8; i++) mq.push_back(v[63-8*i -: 8]);
  endfunction

  function automatic void app_num(input logic [31:0] v);
    for (int i = 0; i < 8; i++) mq.push_back(8'h30 + {4'h0, v[31-4*i -: 4]});
  endfunction

  function automatic bq_t model(input logic [3:0] typ, input logic [63:0] tgt,
                                input logic [31:0] seq, input logic [31:0] beg);
    bq_t body;
    int  blen;
    int  sum;
    mq = {};
    app_str("35=");
    case (typ)
      T_LOGON:  app_str("A");
      T_LOGOUT: app_str("5");
      T_RESEND: app_str("2");
      default:  app_str("0");
    endcase
    mq.push_back(8'h01);
    app_str("49="); app_comp(SENDER); mq.push_back(8'h01);
    app_str("56="); app_comp(tgt);    mq.push_back(8'h01);
    app_str("34="); app_num(seq);     mq.push_back(8'h01);
    if (typ == T_LOGON) begin
      app_str("98=0"); mq.push_back(8'h01); app_str("108=030"); mq.push_back(8'h01);
    end else if (typ == T_RESEND) begin
      app_str("7="); app_num(beg); mq.push_back(8'h01); app_str("16=0"); mq.push_back(8'h01);
    end
    body = mq;
    blen = body.size();
    mq = {};
    app_str("8=FIX.4.2"); mq.push_back(8'h01);
    app_str("9=");
    mq.push_back(8'(48 + blen / 10));
    mq.push_back(8'(48 + blen % 10));
    mq.push_back(8'h01);
    foreach (body[i]) mq.push_back(body[i]);
    sum = 0;
    foreach (mq[i]) sum += int'(mq[i]);
    sum = sum % 256;
    app_str("10=");
    mq.push_back(8'(48 + sum / 100));
    mq.push_back(8'(48 + (sum / 10) % 10));
    mq.push_back(8'(48 + sum % 10));
    mq.push_back(8'h01);
    return mq;
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic bit substr_bad(input bq_t q, input int pos, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (pos + i >= q.size()) return 1'b1;
      if (q[pos+i] !== s[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [63:0] rand_comp();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'($urandom_range(65, 90));
    return v;
  endfunction

  task automatic start_req(input logic [3:0] typ, input logic [63:0] tgt,
                           input logic [31:0] seq, input logic [31:0] beg);
    create_message_i = typ;
    targetCompId_i   = tgt;
    seq_num_i        = seq;
    begin_seq_i      = beg;
    initiate_msg_i   = 1'b1;
    @(posedge clk); #1;
    initiate_msg_i   = 1'b0;
  endtask

  task automatic capture(input bit rnd, input bit inject, output bq_t q,
                         output int stall_err, output int bubbles, output bit timed_out);
    int unsigned cyc;
    bit          stalled;
    bit          fin;
    logic [7:0]  held;
    q = {}; stall_err = 0; bubbles = 0; timed_out = 1'b0;
    cyc = 0; stalled = 1'b0; fin = 1'b0; held = '0;
    while (!fin) begin
      if (cyc >= 2000) begin
        timed_out = 1'b1;
        break;
      end
      tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      initiate_msg_i = inject && (cyc == 5);
      if (initiate_msg_i) create_message_i = T_LOGON;
      if (!tx_valid_o) begin
        bubbles++;
        break;
      end
      if (stalled && tx_data_o !== held) stall_err++;
      if (tx_ready_i) begin
        q.push_back(tx_data_o);
        fin = tx_last_o;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = tx_data_o;
      end
      @(posedge clk); #1;
      cyc++;
    end
    initiate_msg_i = 1'b0;
    tx_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; initiate_msg_i = 1'b0; create_message_i = '0; targetCompId_i = '0;
    seq_num_i = '0; begin_seq_i = '0; tx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, error_o, tx_valid_o, tx_last_o, done_o, tx_data_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b err=%b valid=%b last=%b done=%b data=%h expected all 0",
               busy_o, error_o, tx_valid_o, tx_last_o, done_o, tx_data_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_heartbeat();
    bq_t q, e; int se, bb; bit to;
    e = model(T_HB, "HOSTB001", 32'h00000007, 32'h0);
    start_req(T_HB, "HOSTB001", 32'h00000007, 32'h0);
    checks++;
    if (!(tx_valid_o === 1'b1 && busy_o === 1'b1 && tx_data_o === "8")) begin
      errors++;
      $display("FAIL hb_latency got valid=%b busy=%b data=%h expected 1 1 38", tx_valid_o, busy_o, tx_data_o);
    end
    capture(1'b0, 1'b0, q, se, bb, to);
    checks++;
    if (to || bb != 0) begin
      errors++;
      $display("FAIL hb_stream got timeout=%0b bubbles=%0d expected 0 0", to, bb);
    end
    checks++;
    if (!(done_o === 1'b1 && busy_o === 1'b0)) begin
      errors++;
      $display("FAIL hb_done got done=%b busy=%b expected 1 0", done_o, busy_o);
    end
    checks++;
    if (q.size() != 63) begin
      errors++;
      $display("FAIL hb_len got %0d expected 63", q.size());
    end
    checks++;
    if (substr_bad(q, 10, "9=41") || substr_bad(q, 44, "34=00000007")) begin
      errors++;
      $display("FAIL hb_fields got bodylen/seq wrong expected 9=41 and 34=00000007");
    end
    checks++;
    if (first_diff(q, e) != -1) begin
      errors++;
      $display("FAIL hb_bytes got diff at %0d expected model stream", first_diff(q, e));
    end
    hb_ref = q;
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL hb_done_pulse got done=%b expected 0", done_o);
    end
  endtask

  task automatic test_logon();
    bq_t q, e; int se, bb; bit to;
    logic [63:0] t; logic [31:0] s;
    t = rand_comp(); s = rand_bcd();
    e = model(T_LOGON, t, s, 32'h0);
    start_req(T_LOGON, t, s, 32'h0);
    capture(1'b0, 1'b0, q, se, bb, to);
    checks++;
    if (q.size() != 76 || to) begin
      errors++;
      $display("FAIL logon_len got %0d expected 76", q.size());
    end
    checks++;
    if (substr_bad(q, 10, "9=54") || substr_bad(q, 56, "98=0") || q[60] !== 8'h01 ||
        substr_bad(q, 61, "108=030") || q[68] !== 8'h01) begin
      errors++;
      $display("FAIL logon_fields got bodylen/extra wrong expected 9=54 and 98=0|108=030|");
    end
    checks++;
    if (first_diff(q, e) != -1) begin
      errors++;
      $display("FAIL logon_bytes got diff at %0d expected model stream", first_diff(q, e));
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL logon_done got %b expected 1", done_o);
    end
  endtask

  task automatic test_resend();
    bq_t q, e; int se, bb; bit to;
    e = model(T_RESEND, "HOSTB001", 32'h00000042, 32'h00000123);
    start_req(T_RESEND, "HOSTB001", 32'h00000042, 32'h00000123);
    capture(1'b0, 1'b0, q, se, bb, to);
    checks++;
    if (q.size() != 79 || to) begin
      errors++;
      $display("FAIL resend_len got %0d expected 79", q.size());
    end
    checks++;
    if (substr_bad(q, 10, "9=57") || substr_bad(q, 56, "7=00000123") || q[66] !== 8'h01 ||
        substr_bad(q, 67, "16=0") || q[71] !== 8'h01) begin
      errors++;
      $display("FAIL resend_fields got bodylen/extra wrong expected 9=57 and 7=00000123|16=0|");
    end
    checks++;
    if (first_diff(q, e) != -1) begin
      errors++;
      $display("FAIL resend_bytes got diff at %0d expected model stream", first_diff(q, e));
    end
  endtask

  task automatic test_ready_toggle();
    bq_t q; int se, bb; bit to;
    start_req(T_HB, "HOSTB001", 32'h00000007, 32'h0);
    capture(1'b1, 1'b0, q, se, bb, to);
    checks++;
    if (to || bb != 0) begin
      errors++;
      $display("FAIL toggle_stream got timeout=%0b bubbles=%0d expected 0 0", to, bb);
    end
    checks++;
    if (se != 0) begin
      errors++;
      $display("FAIL toggle_stall got %0d changed stalled bytes expected 0", se);
    end
    checks++;
    if (first_diff(q, hb_ref) != -1) begin
      errors++;
      $display("FAIL toggle_bytes got diff at %0d expected ready-1 stream", first_diff(q, hb_ref));
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL toggle_done got %b expected 1", done_o);
    end
  endtask

  task automatic test_busy_ignore();
    bq_t q, e; int se, bb; bit to;
    e = model(T_HB, "HOSTC777", 32'h00000100, 32'h0);
    start_req(T_HB, "HOSTC777", 32'h00000100, 32'h0);
    capture(1'b0, 1'b1, q, se, bb, to);
    checks++;
    if (first_diff(q, e) != -1 || to) begin
      errors++;
      $display("FAIL busy_bytes got diff at %0d expected single heartbeat", first_diff(q, e));
    end
    @(posedge clk); #1;
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_second got valid=%b busy=%b expected 0 0", tx_valid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    bq_t q, e; int se, bb; bit to;
    logic [31:0] s;
    s = rand_bcd();
    e = model(T_LOGOUT, "HOSTB001", s, 32'h0);
    start_req(T_HB, "HOSTB001", 32'h00000008, 32'h0);
    capture(1'b0, 1'b0, q, se, bb, to);
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got %b expected 1", done_o);
    end
    start_req(T_LOGOUT, "HOSTB001", s, 32'h0);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== "8") begin
      errors++;
      $display("FAIL b2b_accept got valid=%b data=%h expected 1 38", tx_valid_o, tx_data_o);
    end
    capture(1'b0, 1'b0, q, se, bb, to);
    checks++;
    if (first_diff(q, e) != -1 || to) begin
      errors++;
      $display("FAIL b2b_bytes got diff at %0d expected logout stream", first_diff(q, e));
    end
  endtask

  task automatic test_error();
    start_req(4'hF, "HOSTB001", 32'h1, 32'h0);
    checks++;
    if (!(error_o === 1'b1 && busy_o === 1'b0 && tx_valid_o === 1'b0)) begin
      errors++;
      $display("FAIL err_pulse got err=%b busy=%b valid=%b expected 1 0 0", error_o, busy_o, tx_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (!(error_o === 1'b0 && tx_valid_o === 1'b0 && busy_o === 1'b0)) begin
      errors++;
      $display("FAIL err_after got err=%b valid=%b busy=%b expected 0 0 0", error_o, tx_valid_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    bq_t q, e; int se, bb; bit to; bit saw_done;
    logic [63:0] t;
    start_req(T_HB, "HOSTB001", 32'h00000009, 32'h0);
    tx_ready_i = 1'b1;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tx_valid_o, tx_last_o, busy_o, done_o} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_clear got valid=%b last=%b busy=%b done=%b expected 0 0 0 0",
               tx_valid_o, tx_last_o, busy_o, done_o);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_o !== 1'b0 || tx_valid_o !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrst_quiet got activity after reset expected none");
    end
    t = rand_comp();
    e = model(T_HB, t, 32'h00000010, 32'h0);
    start_req(T_HB, t, 32'h00000010, 32'h0);
    capture(1'b0, 1'b0, q, se, bb, to);
    checks++;
    if (first_diff(q, e) != -1 || to) begin
      errors++;
      $display("FAIL midrst_next got diff at %0d expected clean heartbeat", first_diff(q, e));
    end
  endtask

  task automatic test_random();
    bq_t q, e; int se, bb; bit to;
    logic [3:0] typ; logic [63:0] t; logic [31:0] s, b;
    for (int n = 0; n < 8; n++) begin
      typ = 4'($urandom_range(1, 4));
      t = rand_comp(); s = rand_bcd(); b = rand_bcd();
      e = model(typ, t, s, b);
      start_req(typ, t, s, b);
      capture(1'b1, 1'b0, q, se, bb, to);
      checks++;
      if (first_diff(q, e) != -1 || to || bb != 0 || se != 0) begin
        errors++;
        $display("FAIL rand_msg%0d type=%0d got diff at %0d stalls=%0d expected model stream",
                 n, typ, first_diff(q, e), se);
      end
      checks++;
      if (done_o !== 1'b1) begin
        errors++;
        $display("FAIL rand_done%0d got %b expected 1", n, done_o);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_logon();
    test_resend();
    test_ready_toggle();
    test_busy_ignore();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix_msg_transmitter.md
Name: fix_msg_transmitter

Overview:
- Outbound half of the session layer: serialises the admin messages that session_manager requests into a FIX 4.2 byte stream toward the TOE transmit path.
- Inputs: `create_message_o`, `initiate_msg_o` and `targetCompId_o` from session_manager, plus sequence numbers from the sequence generator.
- Builds header, body and trailer on the fly, including BodyLength(9) and CheckSum(10), and drives a valid/ready byte interface.

Parameters:
- VALUE_WIDTH, `VALUE_DATA_WIDTH (64): CompID width; 8 ASCII chars, MSB = first char.
- SENDER_COMP_ID, 64'h0 ("set per build"): own SenderCompID, 8 ASCII chars, MSB first.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- initiate_msg_i  input  1  request strobe (from session_manager `initiate_msg_o`)
- create_message_i  input  4  message type: `logon / `logout / `heartbeat / `resendReq codes from defines.vh
- targetCompId_i  input  VALUE_WIDTH  TargetCompID, 8 ASCII chars
- seq_num_i  input  32  MsgSeqNum(34), 8 BCD digits, MSB digit first
- begin_seq_i  input  32  BeginSeqNo(7) for resendReq, 8 BCD digits
- busy_o  output  1  request in progress; new requests refused
- error_o  output  1  one-cycle pulse: unsupported type dropped
- tx_data_o  output  8  byte out
- tx_valid_o  output  1  byte valid
- tx_ready_i  input  1  sink accepts byte
- tx_last_o  output  1  marks final byte (trailer SOH)
- done_o  output  1  one-cycle pulse after last byte accepted

Behaviour:
- Synchronous active-high reset, clk only.
- Reset values: all outputs 0; FSM in IDLE.

Request acceptance:
- Request accepted when `initiate_msg_i && !busy_o`. Type, target, seq and begin_seq are latched that cycle.
- Requests while busy are ignored; no queue, since session_manager holds off.
- Unsupported type: no bytes emitted, busy_o stays 0, error_o pulses the next cycle.
- Accepted request: busy_o = 1 and tx_valid_o = 1 the next cycle (latency 1) with the first byte '8'.
- busy_o clears in the cycle after the last handshake, the same cycle done_o pulses.
- A new request is accepted at the earliest in the done_o cycle.

Byte handshake:
- A byte transfers when `tx_valid_o && tx_ready_i`.
- While valid and not ready, tx_data_o and tx_last_o hold stable.
- tx_valid_o stays 1 from the first byte to the last; no bubbles once started.

Byte order (SOH = 8'h01):
- Header: "8=FIX.4.2" SOH, then "9=" + BodyLength (2 decimal digits, no leading zero) + SOH.
- Body, common part, in order: "35=" + type char + SOH, "49=" + SENDER + SOH, "56=" + TARGET + SOH, "34=" + 8 digits + SOH. Common part is 41 bytes.
- Type chars: heartbeat '0', resendReq '2', logout '5', logon 'A'.
- Logon extra: "98=0" SOH "108=030" SOH (13 bytes); BodyLength = 54.
- ResendReq extra: "7=" + 8 digits + SOH + "16=0" SOH (16 bytes); BodyLength = 57.
- Heartbeat and logout: no extra; BodyLength = 41.
- Seq fields always 8 digits, zero-padded, emitted as BCD + 8'h30.
- BodyLength is a constant derived from the latched type; no pre-pass.
- Trailer: "10=" + 3 decimal digits + SOH; tx_last_o = 1 on this SOH only.
- Total bytes: 63 for heartbeat/logout, 76 for logon, 79 for resendReq.

CheckSum:
- 8-bit running sum, wraps mod 256, of every byte from '8' through the body's final SOH.
- Updated only on handshake.
- Converted to 3 zero-padded ASCII digits (hundreds/tens/units via compare-subtract) before '1' of "10=" is sent.
- "10=" and the checksum digits are excluded from the sum.

FSM:
- States: IDLE → HDR → BODY_COMMON → BODY_EXTRA (logon/resendReq only) → TRAILER → IDLE.
- A byte index counter within each state selects the byte; it advances only on handshake.

Reset mid-message:
- tx_valid_o, tx_last_o, busy_o and checksum clear the next edge.
- No done_o pulse; the partial message is abandoned.

Test Plan:
- Heartbeat, target "HOSTB001", seq 00000007, tx_ready_i tied 1 → tx_valid_o one cycle after the request; 63 consecutive bytes; "9=41"; "34=00000007"; CheckSum equals the bench model sum mod 256; tx_last_o on byte 63; done_o the next cycle.
- Logon → "9=54", body ends "98=0|108=030|", 76 bytes.
- ResendReq with begin_seq 00000123 → "7=00000123", "16=0", 79 bytes.
- tx_ready_i toggling pseudo-randomly → byte sequence identical to the ready-tied-1 run; tx_data_o stable in every stalled cycle.
- Second initiate_msg_i while busy → ignored, single message out; a request in the done_o cycle is accepted.
- Type 4'b1111 → error_o pulse, no tx_valid_o, busy_o stays 0.
- rst asserted at byte 30 → tx_valid_o = 0 next cycle, no done_o; the following heartbeat is correct from byte 1.
